tmr_scrub_ctrl: RTL and testbench

Scrub controller for a bank of DEPTH triplicated register words, each W bits wide. It periodically sweeps the bank and rewrites the voted value into any word whose three copies disagree, which clears latent single upsets before a second upset can defeat the vote. It owns the bank's per-word write enables and write-data bus, and it merges functional writes from the host with its own scrub writebacks. Functional writes always have priority.

---
 rtl/tmr_scrub_ctrl.sv | 128 ++++++++++++
 tb/tb_tmr_scrub_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_scrub_ctrl.sv
// Scrub controller for a bank of triplicated words: sweeps the mismatch flags,
// rewrites voted data into disagreeing words, and merges host writes ahead of it.
module tmr_scrub_ctrl #(
  parameter int unsigned W      = 10,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PERIOD = 1024,
  parameter int unsigned CW     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   func_we,
  input  logic [$clog2(DEPTH)-1:0] func_addr,
  input  logic [W-1:0]           func_wdata,
  input  logic                   sweep_req,
  input  logic [DEPTH*W-1:0]     bank_q,
  input  logic [DEPTH-1:0]       bank_mis,
  output logic [DEPTH-1:0]       bank_en,
  output logic [W-1:0]           bank_d,
  output logic                   scrub_busy,
  output logic                   sweep_done,
  output logic [CW-1:0]          err_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, FIX, DONE} state_t;

  state_t         state, state_nxt;
  logic [TW-1:0]  timer, timer_nxt;
  logic [AW-1:0]  addr, addr_nxt;
  logic [W-1:0]   fix_data, fix_nxt;
  logic [CW-1:0]  err_nxt;
  logic [DEPTH-1:0] en_nxt;
  logic [W-1:0]   d_nxt;
  logic           last;

  function automatic logic [DEPTH-1:0] onehot(input logic [AW-1:0] a);
    logic [DEPTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      r[i] = (a == AW'(i));
    return r;
  endfunction

  assign last = (addr == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A host write stalls the sweep, except that a write to the word whose fix
  // is pending supersedes that fix and lets the sweep move on.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    fix_nxt   = fix_data;
    err_nxt   = err_count;
    timer_nxt = '0;
    case (state)
      IDLE: begin
        if (timer == TW'(PERIOD - 1) || sweep_req) begin
          state_nxt = SCAN;
          addr_nxt  = '0;
        end
      end
      SCAN: begin
        if (!func_we) begin
          if (bank_mis[addr]) begin
            fix_nxt   = bank_q[addr*W +: W];
            state_nxt = FIX;
          end else if (last) begin
            state_nxt = DONE;
          end else begin
            addr_nxt = addr + 1'b1;
          end
        end
      end
      FIX: begin
        if (!func_we || func_addr == addr) begin
          if (!func_we && err_count != '1)
            err_nxt = err_count + 1'b1;
          if (last) state_nxt = DONE;
          else      addr_nxt  = addr + 1'b1;
          if (!last) state_nxt = SCAN;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state == IDLE && state_nxt == IDLE)
      timer_nxt = timer + 1'b1;
  end

  always_comb begin
    scrub_busy = (state == SCAN) || (state == FIX);
    sweep_done = (state == DONE);
    en_nxt     = '0;
    d_nxt      = bank_d;
    if (func_we) begin
      en_nxt = onehot(func_addr);
      d_nxt  = func_wdata;
    end else if (state == FIX) begin
      en_nxt = onehot(addr);
      d_nxt  = fix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= '0;
      addr      <= '0;
      fix_data  <= '0;
      err_count <= '0;
      bank_en   <= '0;
      bank_d    <= '0;
    end else begin
      timer     <= timer_nxt;
      addr      <= addr_nxt;
      fix_data  <= fix_nxt;
      err_count <= err_nxt;
      bank_en   <= en_nxt;
      bank_d    <= d_nxt;
    end
  end

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed bench for tmr_scrub_ctrl: cadence, correction, host priority,
// dropped fix, forced sweeps, reset mid-fix and counter saturation.
module tb_tmr_scrub_ctrl;

  localparam int W = 10, DEPTH = 8, PERIOD = 16, CW = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rst2 = 1'b1;
  logic               func_we = 1'b0;
  logic [2:0]         func_addr = '0;
  logic [W-1:0]       func_wdata = '0;
  logic               sweep_req = 1'b0;
  logic [DEPTH*W-1:0] bank_q = '0;
  logic [DEPTH-1:0]   bank_mis = '0;

  logic [DEPTH-1:0]   bank_en, bank_en2;
  logic [W-1:0]       bank_d, bank_d2;
  logic               busy, busy2, done, done2;
  logic [CW-1:0]      err;
  logic [1:0]         err2;

  int nvec = 0;
  int nbad = 0;
  int cyc  = 0;

  always #5 clk = ~clk;

  tmr_scrub_ctrl #(.W(W), .DEPTH(DEPTH), .PERIOD(PERIOD), .CW(CW)) dut (
    .clk(clk), .rst(rst), .func_we(func_we), .func_addr(func_addr),
    .func_wdata(func_wdata), .sweep_req(sweep_req), .bank_q(bank_q),
    .bank_mis(bank_mis), .bank_en(bank_en), .bank_d(bank_d),
    .scrub_busy(busy), .sweep_done(done), .err_count(err)
  );

  tmr_scrub_ctrl #(.W(W), .DEPTH(DEPTH), .PERIOD(PERIOD), .CW(2)) dut_sat (
    .clk(clk), .rst(rst2), .func_we(func_we), .func_addr(func_addr),
    .func_wdata(func_wdata), .sweep_req(sweep_req), .bank_q(bank_q),
    .bank_mis(bank_mis), .bank_en(bank_en2), .bank_d(bank_d2),
    .scrub_busy(busy2), .sweep_done(done2), .err_count(err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Examines the current sample, then steps until sweep_done or the bound expires.
  task automatic wait_done(input int limit, output int done_at, output int busy_n,
                           output int en_n, output logic [DEPTH-1:0] last_en,
                           output logic [W-1:0] last_d);
    done_at = -1; busy_n = 0; en_n = 0; last_en = '0; last_d = '0;
    for (int i = 0; i < limit; i++) begin
      if (busy) busy_n++;
      if (bank_en != '0) begin
        en_n++;
        last_en = bank_en;
        last_d  = bank_d;
      end
      if (done) begin
        done_at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic start_sweep(input string tag, output int t0);
    sweep_req = 1'b1;
    tick();
    sweep_req = 1'b0;
    t0 = cyc;
    chk(tag, busy, 1);
  endtask

  logic [2:0]       fa [5] = '{3'd0, 3'd3, 3'd6, 3'd1, 3'd4};
  logic [W-1:0]     fd [5] = '{10'h101, 10'h2B2, 10'h0C3, 10'h3F4, 10'h155};
  logic [DEPTH-1:0] exp_en;
  logic [DEPTH-1:0] le;
  logic [W-1:0]     ld;
  int d, b, e, t0, rr;

  initial begin
    for (int i = 0; i < DEPTH; i++) bank_q[i*W +: W] = W'(i * 37 + 5);
    tick();
    tick();
    chk("rst_en", bank_en, 0);
    chk("rst_d", bank_d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    cyc = 0;

    // idle cadence: SCAN after 16 idle cycles, 8 scan cycles, done every 25
    wait_done(40, d, b, e, le, ld);
    chk("cad_done0", d, 24);
    chk("cad_busy0", b, 8);
    chk("cad_en0", e, 0);
    tick();
    wait_done(40, d, b, e, le, ld);
    chk("cad_done1", d, 49);
    chk("cad_busy1", b, 8);
    chk("cad_en1", e, 0);
    chk("cad_err", err, 0);

    // single correction on word 3
    bank_mis = 8'h08;
    bank_q[3*W +: W] = 10'h2A5;
    tick();
    start_sweep("fix_start", t0);
    wait_done(40, d, b, e, le, ld);
    chk("fix_len", d - t0, 9);
    chk("fix_busy", b, 9);
    chk("fix_hits", e, 1);
    chk("fix_en", le, 8'h08);
    chk("fix_d", ld, 10'h2A5);
    chk("fix_err", err, 1);
    bank_mis = '0;

    // five back-to-back host writes during SCAN
    tick();
    start_sweep("pri_start", t0);
    tick();
    for (int k = 0; k < 5; k++) begin
      func_we    = 1'b1;
      func_addr  = fa[k];
      func_wdata = fd[k];
      tick();
      exp_en = 8'h01 << fa[k];
      chk("pri_en", bank_en, exp_en);
      chk("pri_d", bank_d, fd[k]);
    end
    func_we = 1'b0;
    tick();
    chk("pri_release", bank_en, 0);
    wait_done(40, d, b, e, le, ld);
    chk("pri_len", d - t0, 13);
    chk("pri_hits", e, 0);

    // host write to word 5 during its FIX cycle drops the fix
    bank_mis = 8'h20;
    bank_q[5*W +: W] = 10'h3C3;
    tick();
    start_sweep("drop_start", t0);
    repeat (6) tick();
    chk("drop_pre", bank_en, 0);
    func_we    = 1'b1;
    func_addr  = 3'd5;
    func_wdata = 10'h155;
    tick();
    func_we = 1'b0;
    chk("drop_en", bank_en, 8'h20);
    chk("drop_d", bank_d, 10'h155);
    tick();
    chk("drop_nofix", bank_en, 0);
    wait_done(40, d, b, e, le, ld);
    chk("drop_len", d - t0, 9);
    chk("drop_hits", e, 0);
    chk("drop_err", err, 1);
    bank_mis = '0;

    // forced sweep, request mid-sweep and in DONE both ignored
    tick();
    start_sweep("frc_start", t0);
    repeat (3) tick();
    sweep_req = 1'b1;
    tick();
    sweep_req = 1'b0;
    wait_done(40, d, b, e, le, ld);
    chk("frc_len", d - t0, 8);
    sweep_req = 1'b1;
    tick();
    sweep_req = 1'b0;
    chk("frc_done_req", busy, 0);
    wait_done(40, d, b, e, le, ld);
    chk("frc_next", d - t0, 33);

    // reset during FIX abandons the writeback
    bank_mis = 8'h01;
    tick();
    start_sweep("rfx_start", t0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr = cyc;
    bank_mis = '0;
    chk("rfx_en", bank_en, 0);
    chk("rfx_d", bank_d, 0);
    chk("rfx_busy", busy, 0);
    chk("rfx_done", done, 0);
    chk("rfx_err", err, 0);
    tick();
    chk("rfx_after", bank_en, 0);
    wait_done(40, d, b, e, le, ld);
    chk("rfx_idle", d - rr, 24);

    // five corrections in one sweep; 2-bit counter saturates at 3
    tick();
    rst2 = 1'b0;
    bank_mis = 8'h9B;
    start_sweep("sat_start", t0);
    wait_done(40, d, b, e, le, ld);
    chk("sat_len", d - t0, 13);
    chk("sat_hits", e, 5);
    chk("sat_err16", err, 5);
    chk("sat_err2", err2, 3);
    chk("sat_done2", done2, 1);
    bank_mis = '0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1);
  end

endmodule
